demux_1x4: RTL and testbench

DEMUX_1X4 -- requirements
Module: demux_1x4

---
 rtl/demux_1x4.sv | 134 +++++++++++++
 tb/tb_demux_1x4.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4.sv
// -----------------------------------------------------------------------------
// demux_1x4
//
// Purpose:
//   Registered 1-to-4 demultiplexer for a single data bit. It also keeps an
//   optional per-channel count of din rising edges. Each clock edge routes din
//   to the channel chosen by s and drives the other three channels low. It
//   also registers a one-hot copy of s. No output has a combinational path
//   from din or s.
//
// Configuration macro:
//   DEMUX_1X4_COUNT_EN  - when defined, the din rising-edge detector and the
//                         four saturating counters are built. When undefined,
//                         they are omitted: cnt0..cnt3 are tied to zero and
//                         cnt_clr is ignored.
//
// Parameters:
//   CNT_W    - width of each per-channel edge counter (2..16)
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   din      in   1      data bit to route
//   s        in   2      channel select (0->d0 .. 3->d3)
//   cnt_clr  in   1      synchronous clear of all edge counters
//   d0..d3   out  1      routed data, one cycle latency
//   sel_oh   out  4      registered one-hot of s
//   cnt0..3  out  CNT_W  saturating rising-edge count of din per channel
// -----------------------------------------------------------------------------
module demux_1x4 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [1:0]       s,
    input  logic             cnt_clr,
    output logic             d3,
    output logic             d2,
    output logic             d1,
    output logic             d0,
    output logic [3:0]       sel_oh,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    // One-hot decode of the select. It feeds the sel_oh register, the data
    // routing and the counter enables.
    logic [3:0] sel_d;
    logic [3:0] sel_q;
    logic [3:0] data_d;
    logic [3:0] data_q;

    assign sel_d  = 4'b0001 << s;
    assign data_d = sel_d & {4{din}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 4'b0000;
            data_q <= 4'b0000;
        end else begin
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    assign d0     = data_q[0];
    assign d1     = data_q[1];
    assign d2     = data_q[2];
    assign d3     = data_q[3];
    assign sel_oh = sel_q;

    // Counter values for all channels, gathered so the port mapping is uniform
    // in both build variants.
    logic [3:0][CNT_W-1:0] cnt_all;

`ifdef DEMUX_1X4_COUNT_EN
    logic din_q;
    logic rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    // din_q resets to 0, so din high on the first edge after reset is an edge.
    assign rise = din & ~din_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // A clear wins over a simultaneous increment. A full counter holds
            // its value and does not wrap.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (rise && sel_d[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate
`else
    // cnt_clr has no function without the counters.
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt_all        = '0;
`endif

    assign cnt0 = cnt_all[0];
    assign cnt1 = cnt_all[1];
    assign cnt2 = cnt_all[2];
    assign cnt3 = cnt_all[3];

endmodule

// File: tb/tb_demux_1x4.sv
// -----------------------------------------------------------------------------
// tb_demux_1x4
//
// Purpose:
//   Scoreboard testbench for demux_1x4. It drives two instances with the same
//   stimulus: one uses the default CNT_W=8 and one uses CNT_W=2 to exercise
//   saturation. The driver computes the expected post-edge state from a
//   behavioural model and queues it. A monitor pops one entry after every
//   rising edge and compares it with the outputs.
//
// Configuration:
//   Follows DEMUX_1X4_COUNT_EN like the design. Without the macro, all
//   expected counts are zero.
// -----------------------------------------------------------------------------
module tb_demux_1x4;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic [1:0] s;
    logic       cnt_clr;

    logic       d0, d1, d2, d3;
    logic [3:0] sel_oh;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    logic       sd0, sd1, sd2, sd3;
    logic [3:0] ssel_oh;
    logic [1:0] scnt0, scnt1, scnt2, scnt3;

    demux_1x4 #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .s(s), .cnt_clr(cnt_clr),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .sel_oh(sel_oh),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    demux_1x4 #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(din), .s(s), .cnt_clr(cnt_clr),
        .d3(sd3), .d2(sd2), .d1(sd1), .d0(sd0), .sel_oh(ssel_oh),
        .cnt0(scnt0), .cnt1(scnt1), .cnt2(scnt2), .cnt3(scnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  d;
        logic [3:0]  sel;
        logic [31:0] cw;   // four 8-bit counts, channel 0 in the low byte
        logic [7:0]  cs;   // four 2-bit counts, channel 0 in the low bits
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int bad    = 0;

`ifdef DEMUX_1X4_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    // Behavioural reference state
    int mw[4];
    int ms[4];
    bit prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of the state that the next clock edge should produce for the
    // given inputs.
    function void model_step(bit dn, bit [1:0] ss, bit clr, bit rn);
        exp_t e;
        e = '0;
        if (!rn) begin
            for (int k = 0; k < 4; k++) begin
                mw[k] = 0;
                ms[k] = 0;
            end
            prev = 1'b0;
        end else begin
            if (COUNT_EN) begin
                if (clr) begin
                    for (int k = 0; k < 4; k++) begin
                        mw[k] = 0;
                        ms[k] = 0;
                    end
                end else if (dn && !prev) begin
                    if (mw[ss] < 255) mw[ss] = mw[ss] + 1;
                    if (ms[ss] < 3)   ms[ss] = ms[ss] + 1;
                end
                prev = dn;
            end
            e.d   = dn ? (4'b0001 << ss) : 4'b0000;
            e.sel = 4'b0001 << ss;
            for (int k = 0; k < 4; k++) begin
                e.cw[8*k +: 8] = mw[k][7:0];
                e.cs[2*k +: 2] = ms[k][1:0];
            end
        end
        q.push_back(e);
    endfunction

    task automatic cycle(input bit dn, input bit [1:0] ss, input bit clr, input bit rn);
        @(negedge clk);
        din     = dn;
        s       = ss;
        cnt_clr = clr;
        rst_n   = rn;
        model_step(dn, ss, clr, rn);
    endtask

    // Monitor: every rising edge presents a new output state.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("d",       {28'd0, d3, d2, d1, d0},       {28'd0, e.d});
            chk("sel_oh",  {28'd0, sel_oh},               {28'd0, e.sel});
            chk("cnt_w8",  {cnt3, cnt2, cnt1, cnt0},      e.cw);
            chk("s_d",     {28'd0, sd3, sd2, sd1, sd0},   {28'd0, e.d});
            chk("s_sel",   {28'd0, ssel_oh},              {28'd0, e.sel});
            chk("cnt_w2",  {24'd0, scnt3, scnt2, scnt1, scnt0}, {24'd0, e.cs});
        end
    end

    // Bound on total run time.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout act=running exp=finished");
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

    initial begin
        logic [7:0] exp_c;
        logic [1:0] exp_sc;
        bit [1:0]   rs;

        rst_n = 1'b0; din = 1'b1; s = 2'd2; cnt_clr = 1'b0;

        // Held in reset with din=1, s=2, clock running.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 1'b0, 1'b0);

        // Release: din high on the first edge counts. Then sweep the select
        // with din held high, which must not credit any new edge.
        cycle(1'b1, 2'd0, 1'b0, 1'b1);
        cycle(1'b1, 2'd1, 1'b0, 1'b1);
        cycle(1'b1, 2'd2, 1'b0, 1'b1);
        cycle(1'b1, 2'd3, 1'b0, 1'b1);

        // Clear, then din alternating per edge on channel 1 for 10 cycles.
        cycle(1'b0, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle((i % 2) == 0, 2'd1, 1'b0, 1'b1);
        @(posedge clk); #2;
        exp_c = COUNT_EN ? 8'd5 : 8'd0;
        chk("alt_cnt1", {24'd0, cnt1}, {24'd0, exp_c});

        // Five rising edges on channel 3 saturate the 2-bit counter.
        cycle(1'b0, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle((i % 2) == 0, 2'd3, 1'b0, 1'b1);
        @(posedge clk); #2;
        exp_sc = COUNT_EN ? 2'd3 : 2'd0;
        chk("sat_cnt3", {30'd0, scnt3}, {30'd0, exp_sc});

        // A clear coincident with a rising edge on channel 0, then a new edge.
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b1, 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b1, 2'd0, 1'b1, 1'b1);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b1, 2'd0, 1'b0, 1'b1);

        // Random selects, each held for two cycles, with random din and
        // occasional clears.
        for (int i = 0; i < 20; i++) begin
            rs = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++)
                cycle(1'($urandom_range(0, 1)), rs, $urandom_range(0, 15) == 0, 1'b1);
        end

        // Assert reset between edges: outputs must clear at once.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_d",    {28'd0, d3, d2, d1, d0}, 32'd0);
        chk("async_sel",  {28'd0, sel_oh},         32'd0);
        chk("async_cnt",  {cnt3, cnt2, cnt1, cnt0}, 32'd0);
        chk("async_scnt", {24'd0, scnt3, scnt2, scnt1, scnt0}, 32'd0);
        model_step(1'b1, s, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 1'b0);

        // Resume with a short random run.
        for (int i = 0; i < 12; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b1);

        @(posedge clk); #3;
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
